// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: loads one 16-word block, then streams W[0..ROUNDS-1]
// out of a 16-word sliding window that is refilled with the expanded word.
module sha256_msg_sched #(
   parameter int ROUNDS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] w_data,
   output logic [5:0]  w_idx,
   output logic        w_valid,
   input  logic        w_ready,
   output logic        w_last,
   output logic        busy
);

   typedef enum logic [0:0] {S_LOAD = 1'b0, S_EMIT = 1'b1} state_t;

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
      rotr = (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      sig0 = rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      sig1 = rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  ldcnt_q, ldcnt_d;
   logic [5:0]  t_q, t_d;
   logic [31:0] win_q [16];
   logic [31:0] win_d [16];
   logic [31:0] nxt_s;

   // win[0] = W[t], so this yields W[t+16] for the slot vacated by the shift.
   assign nxt_s = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

   // Outputs come straight from state, counter and window registers.
   assign in_ready = (state_q == S_LOAD);
   assign w_valid  = (state_q == S_EMIT);
   assign w_data   = win_q[0];
   assign w_idx    = t_q;
   assign w_last   = (state_q == S_EMIT) && (t_q == LAST_T);
   assign busy     = (state_q != S_LOAD) || (ldcnt_q != 4'd0);

   // Next-state logic for load/emit sequencing and the window.
   always_comb begin
      state_d = state_q;
      ldcnt_d = ldcnt_q;
      t_d     = t_q;
      win_d   = win_q;
      case (state_q)
         S_LOAD: begin
            if (in_valid) begin
               win_d[ldcnt_q] = in_data;
               ldcnt_d        = ldcnt_q + 4'd1;
               if (ldcnt_q == 4'd15) begin
                  state_d = S_EMIT;
                  t_d     = 6'd0;
               end else begin
                  state_d = S_LOAD;
               end
            end else begin
               state_d = S_LOAD;
            end
         end
         S_EMIT: begin
            if (w_ready) begin
               if (t_q == LAST_T) begin
                  state_d = S_LOAD;
                  t_d     = 6'd0;
               end else begin
                  for (int k = 0; k < 15; k++) begin
                     win_d[k] = win_q[k + 1];
                  end
                  win_d[15] = nxt_s;
                  t_d       = t_q + 6'd1;
               end
            end else begin
               state_d = S_EMIT;
            end
         end
         default: begin
            state_d = S_LOAD;
            ldcnt_d = 4'd0;
            t_d     = 6'd0;
         end
      endcase
   end

   // State registers; reset discards any partial block and clears the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_LOAD;
         ldcnt_q <= 4'd0;
         t_q     <= 6'd0;
         for (int k = 0; k < 16; k++) begin
            win_q[k] <= 32'h0;
         end
      end else begin
         state_q <= state_d;
         ldcnt_q <= ldcnt_d;
         t_q     <= t_d;
         for (int k = 0; k < 16; k++) begin
            win_q[k] <= win_d[k];
         end
      end
   end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Randomized bench for sha256_msg_sched: a 64-round and a 16-round instance share
// stimulus and are checked against a direct FIPS-style schedule model.
module tb_sha256_msg_sched;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        w_ready;

   logic        in_ready, w_valid, w_last, busy;
   logic [31:0] w_data;
   logic [5:0]  w_idx;

   logic        in_ready16, w_valid16, w_last16, busy16;
   logic [31:0] w_data16;
   logic [5:0]  w_idx16;

   int          n_checks = 0;
   int          n_pass   = 0;

   logic [31:0] blk     [16];
   logic [31:0] ref_w   [64];
   logic [31:0] got     [64];
   logic [31:0] abc_got [64];

   sha256_msg_sched #(.ROUNDS(64)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .w_data(w_data), .w_idx(w_idx), .w_valid(w_valid), .w_ready(w_ready),
      .w_last(w_last), .busy(busy)
   );

   sha256_msg_sched #(.ROUNDS(16)) u_dut16 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready16),
      .w_data(w_data16), .w_idx(w_idx16), .w_valid(w_valid16), .w_ready(w_ready),
      .w_last(w_last16), .busy(busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} >> n;
      return d[31:0];
   endfunction

   // Reference schedule from the textbook recurrence over a full 64-entry array.
   task automatic build_ref();
      for (int t = 0; t < 16; t++) ref_w[t] = blk[t];
      for (int t = 16; t < 64; t++)
         ref_w[t] = (rr(ref_w[t-2], 17) ^ rr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                  + ref_w[t-7]
                  + (rr(ref_w[t-15], 7) ^ rr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                  + ref_w[t-16];
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_w_valid"},  w_valid,  32'd0);
      check({tag, "_in_ready"}, in_ready, 32'd1);
      check({tag, "_w_last"},   w_last,   32'd0);
      check({tag, "_busy"},     busy,     32'd0);
      check({tag, "_w_idx"},    w_idx,    32'd0);
      check({tag, "_w_data"},   w_data,   32'd0);
      check({tag, "_v16"},      w_valid16, 32'd0);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      check_reset(tag);
   endtask

   // Feed the first n words of blk, optionally with random idle cycles.
   task automatic load_block(input int n, input bit gaps);
      w_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               in_data  = $urandom;
               @(negedge clk);
               check("gap_w_valid", w_valid, 32'd0);
            end
         end
         check("ld_in_ready", in_ready, 32'd1);
         check("ld_in_ready16", in_ready16, 32'd1);
         check("ld_w_valid", w_valid, 32'd0);
         check("ld_busy", busy, (i != 0) ? 32'd1 : 32'd0);
         in_valid = 1'b1;
         in_data  = blk[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (n == 16) begin
         check("first_w_valid", w_valid, 32'd1);
         check("first_w_idx", w_idx, 32'd0);
      end
   endtask

   // Consume all words (or reset when index stop_at is presented).
   task automatic drain(input bit bp, input int stop_at);
      int          idx = 0;
      int          cyc = 0;
      bit          stalled = 1'b0;
      logic [31:0] hd = 32'h0;
      logic [5:0]  hi = 6'd0;
      while (idx < 64 && cyc < 2000) begin
         if (stalled) begin
            check("hold_data", w_data, hd);
            check("hold_idx", w_idx, {26'd0, hi});
         end
         check("w_valid", w_valid, 32'd1);
         check("w_idx", w_idx, idx);
         check("w_data", w_data, ref_w[idx]);
         check("w_last", w_last, (idx == 63) ? 32'd1 : 32'd0);
         check("emit_in_ready", in_ready, 32'd0);
         check("emit_busy", busy, 32'd1);
         if (idx < 16) begin
            check("r16_valid", w_valid16, 32'd1);
            check("r16_idx", w_idx16, idx);
            check("r16_data", w_data16, blk[idx]);
            check("r16_last", w_last16, (idx == 15) ? 32'd1 : 32'd0);
         end else begin
            check("r16_idle", w_valid16, 32'd0);
         end
         got[idx] = w_data;
         if (idx == stop_at) begin
            w_ready = 1'b1;
            do_reset("mid_emit");
            return;
         end
         w_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = !w_ready;
         hd = w_data;
         hi = w_idx;
         if (w_ready) idx++;
         @(negedge clk);
         cyc++;
      end
      if (idx < 64) check("drain_timeout", idx, 32'd64);
      check("end_w_valid", w_valid, 32'd0);
      check("end_in_ready", in_ready, 32'd1);
      check("end_busy", busy, 32'd0);
   endtask

   task automatic rand_block();
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      build_ref();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; w_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_reset("por");

      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[0]  = 32'h61626380;
      blk[15] = 32'h00000018;
      build_ref();
      load_block(16, 1'b0);
      drain(1'b0, -1);
      check("abc_w16", got[16], 32'h61626380);
      check("abc_w17", got[17], 32'h000F0000);
      for (int i = 0; i < 64; i++) abc_got[i] = got[i];

      load_block(16, 1'b0);
      drain(1'b1, -1);
      for (int i = 0; i < 64; i++) check("bp_same", got[i], abc_got[i]);

      for (int i = 0; i < 16; i++) blk[i] = 32'h0;
      blk[1] = 32'h00000001;
      build_ref();
      load_block(16, 1'b1);
      drain(1'b1, -1);
      check("sig0_w16", got[16], 32'h02004000);

      for (int b = 0; b < 3; b++) begin
         rand_block();
         load_block(16, 1'b1);
         drain(1'b1, -1);
      end

      rand_block();
      load_block(5, 1'b1);
      in_valid = 1'b1;
      in_data  = $urandom;
      do_reset("mid_load");
      rand_block();
      load_block(16, 1'b1);
      drain(1'b1, -1);

      rand_block();
      load_block(16, 1'b0);
      drain(1'b1, 20);
      rand_block();
      load_block(16, 1'b1);
      drain(1'b1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Sequences the SHA-256 message-schedule datapath.
- Accepts one 512-bit block as 16 big-endian 32-bit words over a valid/ready stream.
- Emits the 64 schedule words W[0..63] to the round engine over a second valid/ready stream.
- Expansion uses σ0 = ROTR7 ^ ROTR18 ^ SHR3 and σ1 = ROTR17 ^ ROTR19 ^ SHR10, built from the team's existing rotate primitives.
- Sits between the block padder and the compression-round controller.

Parameters:
- ROUNDS, 64, number of schedule words emitted per block (legal range 16..64).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  32  message word; first word accepted is W[0].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- w_data  output  32  schedule word W[t].
- w_idx  output  6  index t of w_data.
- w_valid  output  1  w_data/w_idx are valid.
- w_ready  input  1  consumer accepts W[t] this cycle.
- w_last  output  1  asserted with w_valid when t == ROUNDS-1.
- busy  output  1  high in any state other than LOAD with load count 0.

Behaviour:
- Storage is a 16-entry window win[0..15] of 32-bit words. In EMIT, win[0] holds W[t] and win[k] holds W[t+k].
- Next-word datapath (combinational): nxt = σ1(win[14]) + win[9] + σ0(win[1]) + win[0], computed mod 2^32 with carries discarded.
- States:
  - LOAD: in_ready=1, w_valid=0.
    - Each accepted word (in_valid & in_ready) is written to win[ldcnt]; the 4-bit counter ldcnt then increments.
    - When the word accepted is the one with ldcnt==15: go to EMIT, set t=0, ldcnt wraps to 0.
  - EMIT: in_ready=0, w_valid=1, w_data=win[0], w_idx=t, w_last=(t==ROUNDS-1).
    - On handshake with t<ROUNDS-1: window shifts (win[k] <= win[k+1] for k=0..14, win[15] <= nxt) and t increments.
    - On handshake with t==ROUNDS-1: go to LOAD; window contents are don't-care.
    - With w_ready=0, all outputs and state hold stable (no combinational dependence of w_valid/w_data on w_ready).
- Timing:
  - First W[0] is valid the cycle after the 16th input word is accepted.
  - Then one word per cycle under continuous w_ready. Block throughput is 16 + ROUNDS cycles with no overlap: no input is accepted while in EMIT.
- w_data and w_idx are driven from registers or the window only, with no arithmetic on the output path. nxt is only consumed into win[15].
- Reset (including mid-LOAD or mid-EMIT) is synchronous and active-high. After reset:
  - state=LOAD, ldcnt=0, t=0.
  - in_ready=1, w_valid=0, w_last=0, busy=0, w_idx=0, w_data=0.
  - Window cleared to 0.
  - A partially loaded block is discarded; rst wins over any concurrent handshake.
- in_valid while in EMIT is ignored (in_ready=0); upstream must hold the word.
- Simultaneous last-word accept and consumer w_ready: w_valid is still 0 that cycle, so no output handshake occurs.
- w_idx wraps never: t saturates at ROUNDS-1 and the state leaves EMIT.

Test Plan:
- "abc" padded block: W0=0x61626380, W1..W14=0, W15=0x00000018, w_ready=1 continuously.
  - Required: W16=0x61626380 and W17=0x000F0000.
  - All 64 words match the software golden model.
  - w_last high only at w_idx=63; in_ready returns to 1 the next cycle.
- σ0 / rotate-18 check: W1=0x00000001, all others 0 → W16=0x02004000.
- Backpressure: same block, w_ready toggled pseudo-randomly.
  - w_data/w_idx stay stable while w_valid & !w_ready.
  - Output sequence is identical to the unstalled run.
- Input gaps: in_valid deasserted randomly during LOAD → ldcnt advances only on handshakes, and the first W[0] appears exactly one cycle after the 16th accept.
- Reset mid-EMIT at t=20, then a fresh block loaded:
  - After reset, w_valid=0 and in_ready=1.
  - New block output starts at w_idx=0 with correct values and no stale data.
- ROUNDS=16 build: emits W0..W15 unchanged; w_last at w_idx=15.
